// File: rtl/exceptionull_pkg.sv
// Shared opcode constants, state encoding and decode helper for cpu_sequencer.
// Optional build macro: SEQ_OVERFLOW_TRAP_EN adds the TRAP state.
package exceptionull_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

  // The ALU reports a taken jump/branch as all ones.
  localparam logic [7:0] JUMP_TAKEN = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_ALU_WAIT = 4'd4,
    ST_MEM      = 4'd5,
    ST_WB       = 4'd6,
    ST_HALT     = 4'd7
`ifdef SEQ_OVERFLOW_TRAP_EN
    , ST_TRAP   = 4'd8
`endif
  } seq_state_t;

  // Opcodes that write the ALU result (or link address) straight from ALU_WAIT.
  // Loads write in WB too, but their data comes from the MEM path.
  function automatic logic alu_path_writes(input logic [3:0] op);
    return (op[3] == 1'b0) || (op[3:1] == 3'b111) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between cpu_sequencer and its instruction memory, ALU,
// register file and data memory. master = sequencer side.
interface cpu_sequencer_if;

  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;

  logic [7:0] alu_instr;
  logic [7:0] alu_pc;
  logic [7:0] alu_out;
  logic [7:0] alu_jump;
  logic       alu_overflow;

  logic [1:0] rf_ra0;
  logic [1:0] rf_ra1;
  logic [7:0] rf_rd0;
  logic [7:0] rf_rd1;
  logic       rf_we;
  logic [1:0] rf_wa;
  logic [7:0] rf_wd;

  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic       dmem_ack;
  logic [7:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_data,
    output alu_instr, alu_pc, input alu_out, alu_jump, alu_overflow,
    output rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd, input rf_rd0, rf_rd1,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );

  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_data,
    input alu_instr, alu_pc, output alu_out, alu_jump, alu_overflow,
    input rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd, output rf_rd0, rf_rd1,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/seq_pc_next.sv
// Next program counter for the write-back step, plus a wrap flag that marks
// a sequential (non-jump) advance rolling past 8'hFF.
module seq_pc_next
  import exceptionull_pkg::*;
(
  input  logic [7:0] pc,
  input  logic [3:0] opcode,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_jump,
  output logic [7:0] next_pc,
  output logic       wrap
);

  logic       taken;
  logic [7:0] pc_inc;

  // Select jump target, branch skip or sequential increment (all mod 256).
  always_comb begin
    pc_inc  = pc + 8'd1;
    taken   = 1'b0;
    next_pc = pc_inc;
    if (alu_jump == JUMP_TAKEN) begin
      if (opcode == OP_J || opcode == OP_JAL) begin
        taken   = 1'b1;
        next_pc = pc_inc + alu_out;
      end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
        taken   = 1'b1;
        next_pc = pc + 8'd2;
      end
    end
    wrap = !taken && (next_pc < pc);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, ALU issue, optional data
// memory access, register write-back and pc update.
// Optional build macro: SEQ_OVERFLOW_TRAP_EN (ADD overflow enters TRAP).
//
// state    | meaning
// IDLE     | waiting for start pulse
// FETCH    | imem_req held until imem_ack, instruction latched
// DECODE   | register operands read
// EXEC     | one-cycle ALU issue
// ALU_WAIT | ALU result sampled, route to MEM or WB
// MEM      | dmem_req held until dmem_ack
// WB       | register write pulse, pc update
// HALT     | sequential pc wrapped; stays until rst
// TRAP     | ADD overflow (macro builds only); stays until rst
module cpu_sequencer
  import exceptionull_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  cpu_sequencer_if.master  bus,
  output logic [7:0]       pc,
  output logic             busy,
  output logic             halted,
  output logic             trap
);

  seq_state_t state;
  logic [7:0] ir;
  logic [7:0] rd0_q;
  logic [7:0] rd1_q;
  logic [7:0] alu_out_q;
  logic [7:0] alu_jump_q;
  logic [7:0] next_pc;
  logic       wrap;
  logic [3:0] op;

  assign op         = ir[7:4];
  assign bus.rf_ra0 = ir[3:2];
  assign bus.rf_ra1 = ir[1:0];

  seq_pc_next u_pc_next (
    .pc       (pc),
    .opcode   (op),
    .alu_out  (alu_out_q),
    .alu_jump (alu_jump_q),
    .next_pc  (next_pc),
    .wrap     (wrap)
  );

`ifndef SEQ_OVERFLOW_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = bus.alu_overflow;
  assign trap            = 1'b0;
`endif

  // Sequencer FSM; every output is set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pc             <= 8'd0;
      ir             <= 8'd0;
      rd0_q          <= 8'd0;
      rd1_q          <= 8'd0;
      alu_out_q      <= 8'd0;
      alu_jump_q     <= 8'd0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.imem_addr  <= 8'd0;
      bus.alu_instr  <= 8'd0;
      bus.alu_pc     <= 8'd0;
      bus.rf_we      <= 1'b0;
      bus.rf_wa      <= 2'd0;
      bus.rf_wd      <= 8'd0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= 8'd0;
      bus.dmem_wdata <= 8'd0;
`ifdef SEQ_OVERFLOW_TRAP_EN
      trap           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_FETCH;
            busy          <= 1'b1;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            ir           <= bus.imem_data;
            state        <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rd0_q         <= bus.rf_rd0;
          rd1_q         <= bus.rf_rd1;
          bus.alu_instr <= ir;
          bus.alu_pc    <= pc;
          state         <= ST_EXEC;
        end
        ST_EXEC: begin
          bus.alu_instr <= 8'd0;
          bus.alu_pc    <= 8'd0;
          state         <= ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          alu_out_q  <= bus.alu_out;
          alu_jump_q <= bus.alu_jump;
`ifdef SEQ_OVERFLOW_TRAP_EN
          if (op == OP_ADD && bus.alu_overflow) begin
            state <= ST_TRAP;
            trap  <= 1'b1;
            busy  <= 1'b0;
          end else
`endif
          if (op == OP_LW || op == OP_SW) begin
            state          <= ST_MEM;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= (op == OP_SW);
            bus.dmem_addr  <= rd1_q;
            bus.dmem_wdata <= rd0_q;
          end else begin
            state     <= ST_WB;
            bus.rf_we <= alu_path_writes(op);
            bus.rf_wa <= (op == OP_JAL) ? 2'b11 : ir[1:0];
            bus.rf_wd <= (op == OP_JAL) ? (pc + 8'd1) : bus.alu_out;
          end
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus.rf_we    <= (op == OP_LW);
            bus.rf_wa    <= ir[1:0];
            bus.rf_wd    <= bus.dmem_rdata;
            state        <= ST_WB;
          end
        end
        ST_WB: begin
          bus.rf_we <= 1'b0;
          if (wrap) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            pc            <= next_pc;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= next_pc;
            state         <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
`ifdef SEQ_OVERFLOW_TRAP_EN
        ST_TRAP: begin
          state <= ST_TRAP;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins execution from IDLE.
REQ-004 SHALL have ports imem_req (out, 1), imem_addr (out, 8), imem_ack (in, 1), imem_data (in, 8): instruction fetch handshake.
REQ-005 SHALL have ports alu_instr (out, 8), alu_pc (out, 8), alu_out (in, 8), alu_jump (in, 8), alu_overflow (in, 1): drive and sample the clocked 8-bit ALU.
REQ-006 SHALL have ports rf_ra0 (out, 2) = instr[3:2], rf_ra1 (out, 2) = instr[1:0], rf_rd0 (in, 8), rf_rd1 (in, 8), rf_we (out, 1), rf_wa (out, 2), rf_wd (out, 8): register file.
REQ-007 SHALL have ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, 8), dmem_wdata (out, 8), dmem_ack (in, 1), dmem_rdata (in, 8): data memory handshake.
REQ-008 SHALL have ports pc (out, 8), busy (out, 1), halted (out, 1), trap (out, 1).

Function
REQ-009 SHALL implement states IDLE, FETCH, DECODE, EXEC, ALU_WAIT, MEM, WB, HALT, TRAP.
REQ-010 IDLE: start=1 -> FETCH, pc unchanged; otherwise remain in IDLE; start is ignored in all other states.
REQ-011 FETCH: imem_req=1, imem_addr=pc, held until imem_ack=1; on ack, latch imem_data into the instruction register -> DECODE.
REQ-012 DECODE: one cycle; rf_ra0/rf_ra1 valid; rf_rd0/rf_rd1 sampled at the end of the cycle -> EXEC.
REQ-013 EXEC: alu_instr=instruction register, alu_pc=pc for exactly one cycle -> ALU_WAIT; ALU result is valid one cycle after issue.
REQ-014 ALU_WAIT: sample alu_out, alu_jump, alu_overflow; opcodes 1010/1011 -> MEM; all others -> WB.
REQ-015 MEM: dmem_req=1, dmem_addr=rf_rd1, dmem_wdata=rf_rd0, dmem_we=1 for opcode 1011 and 0 for opcode 1010; held until dmem_ack -> WB.
REQ-016 WB: rf_we=1 for one cycle for opcodes 0000-0111 and 1110-1111 (wd=alu_out, wa=instr[1:0]), for 1010 (wd=dmem_rdata, wa=instr[1:0]), and for 1001 (wd=pc+1, wa=2'b11); no write for 1000, 1011, 1100, 1101.
REQ-017 WB next-pc: J/JAL with alu_jump=8'hFF -> pc+1+alu_out; BEQ/BNE with alu_jump=8'hFF -> pc+2; otherwise pc+1; all arithmetic modulo 256.
REQ-018 WB: when next-pc wraps to a value numerically less than pc without a jump -> HALT; otherwise -> FETCH.
REQ-019 HALT: halted=1, busy=0; stays in HALT until rst.
REQ-020 busy=1 in every state except IDLE, HALT and TRAP.
REQ-021 Outputs SHALL be registered; req signals SHALL never drop before their ack.

Reset
REQ-022 rst=1 SHALL force IDLE, pc=0, instruction register=0, all req/we outputs 0, alu_instr=0, busy/halted/trap=0 on the next edge, including mid-handshake; a pending ack SHALL be ignored.

Configuration
REQ-023 With SEQ_OVERFLOW_TRAP_EN defined, an opcode 0001 with alu_overflow=1 sampled in ALU_WAIT SHALL go to TRAP (no register write, pc held, trap=1 until rst).
REQ-024 Without SEQ_OVERFLOW_TRAP_EN, overflow SHALL be ignored, the trap output SHALL be tied to 0, and the TRAP state SHALL be absent.

Structure
REQ-025 The opcode constants (4-bit) and the state encoding SHALL live in the shared package exceptionull_pkg.
REQ-026 Next-pc computation SHALL be a sub-module seq_pc_next (inputs pc, opcode, alu_out, alu_jump; output next_pc, wrap).

Verification
REQ-027 rst, start, imem returns 8'h1D (ADD) with ack after 2 cycles -> imem_req held 3 cycles, rf_we=1 with wa=1 and wd=alu_out, pc=1.
REQ-028 JAL at pc=8'h05, alu_out=8'h0A, jump=FF -> r3 written with 8'h06, pc=8'h10.
REQ-029 BNE taken at pc=8'h20 -> pc=8'h22, no rf write; BNE not taken -> pc=8'h21.
REQ-030 LW with dmem_ack delayed 4 cycles -> dmem_req high 5 cycles, dmem_we=0, rf_wd=dmem_rdata.
REQ-031 pc=8'hFF non-jump instruction -> HALT, halted=1; start ignored afterward.
REQ-032 rst asserted during FETCH with imem_ack=1 in the same cycle -> IDLE, pc=0, no instruction latched; with SEQ_OVERFLOW_TRAP_EN, ADD 8'h7F+8'h01 -> trap=1, no write.
